gate_vector_sequencer: RTL and testbench



---
 rtl/gate_test_pkg.sv | 21 ++
 rtl/gate_ref_model.sv | 14 +
 rtl/gate_vector_sequencer.sv | 123 ++++++++++++
 tb/tb_gate_vector_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate-cell test sequencer and its golden model.
// Vector index i maps to the gate inputs {a,b} = i.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int NUM_VECTORS = 4;
    localparam int VEC_W       = 2;
    localparam int CNT_W       = 8;

    // Vectors are applied in ascending order: 00, 01, 10, 11.
    function automatic logic [1:0] vec_to_ab(input logic [VEC_W-1:0] vec);
        return vec;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the two-input and/or/xor gate cells.
module gate_ref_model (
    input  logic a,
    input  logic b,
    output logic exp_and,
    output logic exp_or,
    output logic exp_xor
);

    assign exp_and = a & b;
    assign exp_or  = a | b;
    assign exp_xor = a ^ b;

endmodule

// File: rtl/gate_vector_sequencer.sv
// Drives all four input combinations into the gate cells, lets each settle, and
// scores the sampled outputs against the golden model.
module gate_vector_sequencer
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    input  logic             y_and,
    input  logic             y_or,
    input  logic             y_xor,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       fail_vec
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;

    logic exp_and, exp_or, exp_xor;
    logic vec_match;
    logic mismatch;

    gate_ref_model u_ref (
        .a       (a_q),
        .b       (b_q),
        .exp_and (exp_and),
        .exp_or  (exp_or),
        .exp_xor (exp_xor)
    );

    assign vec_match = ({y_and, y_or, y_xor} == {exp_and, exp_or, exp_xor});

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        err_d    = err_q;
        fail_d   = fail_q;
        // An unknown compare result never clears the flag, so X/Z on y_* scores as a miss.
        mismatch = 1'b1;
        if (vec_match) mismatch = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = SETTLE;
                    vec_d      = '0;
                    cnt_d      = '0;
                    {a_d, b_d} = vec_to_ab('0);
                    err_d      = '0;
                    fail_d     = '0;
                end
            end
            SETTLE: begin
                if (cnt_q == LAST_CNT) state_d = SAMPLE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            SAMPLE: begin
                if (mismatch) begin
                    fail_d[vec_q] = 1'b1;
                    if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                end
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    state_d    = SETTLE;
                    vec_d      = vec_q + 1'b1;
                    cnt_d      = '0;
                    {a_d, b_d} = vec_to_ab(vec_q + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_q == '0);
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Scoreboard bench: the stimulus queues expected vectors and run results, a monitor checks them.
module tb_gate_vector_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, start1;
    logic       a, b, y_and, y_or, y_xor, busy, done, pass;
    logic [7:0] err_count;
    logic [3:0] fail_vec;
    logic       a1, b1, y1_and, y1_or, y1_xor, busy1, done1, pass1;
    logic [0:0] err1;
    logic [3:0] fail1;
    int         fault;
    int         cyc = 0;

    typedef struct {
        int err;
        int fail;
        int pass;
        int done_cyc;
    } res_t;

    res_t       exp_q[$];
    logic [1:0] ab_q[$];
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate cells under test, with selectable faults: 0 good, 1 xor stuck 0, 2 and stuck 1, 3 inverted.
    always_comb begin
        y_and = a & b;
        y_or  = a | b;
        y_xor = a ^ b;
        case (fault)
            1: y_xor = 1'b0;
            2: y_and = 1'b1;
            3: begin
                y_and = ~(a & b);
                y_or  = ~(a | b);
                y_xor = ~(a ^ b);
            end
            default: ;
        endcase
    end

    assign y1_and = ~(a1 & b1);
    assign y1_or  = ~(a1 | b1);
    assign y1_xor = ~(a1 ^ b1);

    gate_vector_sequencer #(.SETTLE_CYCLES(4), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .y_and(y_and), .y_or(y_or), .y_xor(y_xor), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
    );

    gate_vector_sequencer #(.SETTLE_CYCLES(1), .ERR_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .y_and(y1_and), .y_or(y1_or), .y_xor(y1_xor), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_vec(fail1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: checks each new vector driven while busy, and the result when done rises.
    initial begin
        logic       busy_p;
        logic       done_p;
        logic [1:0] ab_p;
        res_t       r;
        busy_p = 1'b0;
        done_p = 1'b0;
        ab_p   = 2'b00;
        forever begin
            @(negedge clk);
            if (busy && (!busy_p || {a, b} != ab_p)) begin
                if (ab_q.size() == 0) check("unexpected_vector", {30'd0, a, b}, 32'hFFFF_FFFF);
                else                  check("vec_ab", {30'd0, a, b}, {30'd0, ab_q.pop_front()});
            end
            if (done && !done_p) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    check("err_count", {24'd0, err_count}, r.err);
                    check("fail_vec", {28'd0, fail_vec}, r.fail);
                    check("pass", {31'd0, pass}, r.pass);
                    check("done_cycle", cyc, r.done_cyc);
                    check("busy_in_done", {31'd0, busy}, 32'd0);
                end
            end
            busy_p = busy;
            done_p = done;
            ab_p   = {a, b};
        end
    end

    task automatic queue_run(input int e_err, input int e_fail, input int e_pass);
        res_t r;
        r.err      = e_err;
        r.fail     = e_fail;
        r.pass     = e_pass;
        r.done_cyc = cyc + 21;
        exp_q.push_back(r);
        for (int i = 0; i < 4; i++) ab_q.push_back(2'(i));
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
            ab_q.delete();
        end
    endtask

    // Issues one run; hold keeps start high until done is seen.
    task automatic run(input int f, input int e_err, input int e_fail, input int e_pass,
                       input bit hold, input bit chk_clear);
        @(negedge clk);
        fault = f;
        start = 1'b1;
        queue_run(e_err, e_fail, e_pass);
        @(negedge clk);
        if (chk_clear) begin
            check("restart_err", {24'd0, err_count}, 32'd0);
            check("restart_fail", {28'd0, fail_vec}, 32'd0);
            check("restart_done", {31'd0, done}, 32'd0);
            check("restart_busy", {31'd0, busy}, 32'd1);
        end
        if (!hold) start = 1'b0;
        wait_done(60);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        fault  = 0;
        #1;
        check("rst_a", {31'd0, a}, 32'd0);
        check("rst_b", {31'd0, b}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_err", {24'd0, err_count}, 32'd0);
        check("rst_fail", {28'd0, fail_vec}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Narrow counter, one-cycle settle, all outputs inverted: 1 + 4*2 = 9 cycles.
        @(negedge clk);
        start1 = 1'b1;
        n = cyc;
        @(negedge clk);
        start1 = 1'b0;
        while (!done1 && cyc - n < 40) @(negedge clk);
        check("d1_done_cycle", cyc - n, 32'd9);
        check("d1_fail_vec", {28'd0, fail1}, 32'hF);
        check("d1_err_sat", {31'd0, err1}, 32'd1);
        check("d1_pass", {31'd0, pass1}, 32'd0);

        run(0, 0, 4'b0000, 1, 1'b0, 1'b0);
        run(1, 2, 4'b0110, 0, 1'b0, 1'b0);
        run(2, 3, 4'b0111, 0, 1'b0, 1'b0);
        run(1, 2, 4'b0110, 0, 1'b1, 1'b0);
        run(0, 0, 4'b0000, 1, 1'b0, 1'b1);

        // Abort during the settle window of vector 2.
        @(negedge clk);
        fault = 0;
        start = 1'b1;
        queue_run(0, 0, 1);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ({a, b} != 2'b10 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_vec2", {30'd0, a, b}, 32'd2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_a", {31'd0, a}, 32'd0);
        check("abort_b", {31'd0, b}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_err", {24'd0, err_count}, 32'd0);
        check("abort_fail", {28'd0, fail_vec}, 32'd0);
        exp_q.delete();
        ab_q.delete();
        #3 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);

        run(0, 0, 4'b0000, 1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("pending_results", exp_q.size(), 32'd0);
        check("pending_vectors", ab_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
